// File: rtl/gaus_sched_pkg.sv
// Shared types and constants for the Gaussian-filter frame scheduler:
// FSM state encoding, err_status bit positions and the frame counter width.
package gaus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } sched_state_e;

  localparam int ERR_LINE = 0;  // line length differs from IMG_WIDTH / stray beat while draining
  localparam int ERR_SOF  = 1;  // start of frame arrived before the frame was complete
  localparam int ERR_WDOG = 2;  // input went idle for too long inside a frame
  localparam int ERR_W    = 3;

  localparam int FCNT_W   = 16;

endpackage

// File: rtl/gaus_sched_wdog.sv
// Idle watchdog for the frame scheduler: counts consecutive cycles without
// a beat while armed, clears on any beat or when disarmed, and flags expiry
// on the cycle the idle run reaches WDOG_CYC. Only instantiated when
// GAUS_SCHED_WDOG_EN is defined.
module gaus_sched_wdog #(
  parameter int WDOG_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic beat,
  output logic expire
);

  localparam int IW = $clog2(WDOG_CYC + 1);

  logic [IW-1:0] idle_r;

  // Expiry is raised on the idle cycle that completes the WDOG_CYC-long run.
  assign expire = enable && !beat && (idle_r == IW'(WDOG_CYC - 1));

  // Consecutive-idle counter; any beat, disarm or expiry restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_r <= '0;
    end else if (!enable || beat || expire) begin
      idle_r <= '0;
    end else begin
      idle_r <= idle_r + IW'(1);
    end
  end

endmodule

// File: rtl/gaus_frame_sched.sv
// Frame-level controller for the 3x3 Gaussian filter stage.
// Watches the AXI-Stream sideband at the filter input, latches the software
// enable request only at accepted start-of-frame, tracks line/column
// position, flags geometry errors and pulses frame_done once the filter
// pipeline has drained (PIPE_LAT cycles after the last end-of-line).
// Optional idle watchdog: define GAUS_SCHED_WDOG_EN.
module gaus_frame_sched
  import gaus_sched_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIPE_LAT   = 5,
  parameter int CNT_W      = 12,
  parameter int WDOG_CYC   = 4096
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  input  logic              gaus_en_req,
  input  logic              err_clr,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic              gaus_en,
  output logic              frame_active,
  output logic              frame_done,
  output logic [CNT_W-1:0]  line_cnt,
  output logic [CNT_W-1:0]  col_cnt,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [ERR_W-1:0]  err_status
);

  localparam int DRN_W = $clog2(PIPE_LAT + 1);
  localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] HEIGHT_C = CNT_W'(IMG_HEIGHT);

  // Bits that can ever be set; the watchdog bit stays 0 without the watchdog.
`ifdef GAUS_SCHED_WDOG_EN
  localparam logic [ERR_W-1:0] ERR_MASK = 3'b111;
`else
  localparam logic [ERR_W-1:0] ERR_MASK = 3'b011;
`endif

  // Geometry must fit the counters; reject bad configurations at elaboration.
  generate
    if (IMG_WIDTH < 1 || IMG_WIDTH >= (1 << CNT_W)) begin : g_bad_width
      $error("gaus_frame_sched: IMG_WIDTH must be in 1 .. 2**CNT_W-1");
    end
    if (IMG_HEIGHT < 1 || IMG_HEIGHT >= (1 << CNT_W)) begin : g_bad_height
      $error("gaus_frame_sched: IMG_HEIGHT must be in 1 .. 2**CNT_W-1");
    end
    if (PIPE_LAT < 1) begin : g_bad_lat
      $error("gaus_frame_sched: PIPE_LAT must be at least 1");
    end
    if (WDOG_CYC < 1) begin : g_bad_wdog
      $error("gaus_frame_sched: WDOG_CYC must be at least 1");
    end
  endgenerate

  sched_state_e      state_r, state_nxt;
  logic              gaus_en_r, gaus_en_nxt;
  logic              active_r, active_nxt;
  logic              done_r, done_nxt;
  logic [CNT_W-1:0]  line_r, line_nxt;
  logic [CNT_W-1:0]  col_r, col_nxt;
  logic [FCNT_W-1:0] fcnt_r, fcnt_nxt;
  logic [ERR_W-1:0]  err_r, err_nxt;
  logic [DRN_W-1:0]  drain_r, drain_nxt;
  logic [ERR_W-1:0]  err_set_s;
  logic              beat_s;
  logic              sof_s;
  logic              eol_s;
  logic              wdog_expire_s;

  // Sideband is only meaningful on a beat.
  assign beat_s = s_axis_tvalid;
  assign sof_s  = s_axis_tvalid & s_axis_tuser;
  assign eol_s  = s_axis_tvalid & s_axis_tlast;

`ifdef GAUS_SCHED_WDOG_EN
  gaus_sched_wdog #(
    .WDOG_CYC (WDOG_CYC)
  ) u_wdog (
    .clk    (pixel_clk),
    .rst_n  (rst_n),
    .enable (state_r == ACTIVE),
    .beat   (beat_s),
    .expire (wdog_expire_s)
  );
`else
  assign wdog_expire_s = 1'b0;
`endif

  // Next-state, counter and error-event decode for the frame FSM.
  always_comb begin
    state_nxt   = state_r;
    gaus_en_nxt = gaus_en_r;
    line_nxt    = line_r;
    col_nxt     = col_r;
    fcnt_nxt    = fcnt_r;
    drain_nxt   = drain_r;
    done_nxt    = 1'b0;
    err_set_s   = '0;

    case (state_r)
      IDLE: begin
        if (sof_s) begin
          state_nxt   = ACTIVE;
          gaus_en_nxt = gaus_en_req;
          line_nxt    = '0;
          col_nxt     = CNT_W'(1);
        end else begin
          state_nxt = IDLE;
        end
      end

      ACTIVE: begin
        if (sof_s) begin
          // Premature SOF restarts the frame; it wins over a coincident tlast.
          err_set_s[ERR_SOF] = 1'b1;
          state_nxt          = ACTIVE;
          gaus_en_nxt        = gaus_en_req;
          line_nxt           = '0;
          col_nxt            = CNT_W'(1);
        end else if (eol_s) begin
          err_set_s[ERR_LINE] = ((col_r + CNT_W'(1)) != WIDTH_C);
          col_nxt             = '0;
          line_nxt            = line_r + CNT_W'(1);
          if ((line_r + CNT_W'(1)) == HEIGHT_C) begin
            state_nxt = FLUSH;
            drain_nxt = DRN_W'(PIPE_LAT);
          end else begin
            state_nxt = ACTIVE;
          end
        end else if (beat_s) begin
          col_nxt   = col_r + CNT_W'(1);
          state_nxt = ACTIVE;
        end else if (wdog_expire_s) begin
          err_set_s[ERR_WDOG] = 1'b1;
          state_nxt           = IDLE;
        end else begin
          state_nxt = ACTIVE;
        end
      end

      FLUSH: begin
        drain_nxt = drain_r - DRN_W'(1);
        if (sof_s) begin
          // Back-to-back frame: finish the old one and open the new one now.
          done_nxt    = 1'b1;
          fcnt_nxt    = fcnt_r + FCNT_W'(1);
          state_nxt   = ACTIVE;
          drain_nxt   = '0;
          gaus_en_nxt = gaus_en_req;
          line_nxt    = '0;
          col_nxt     = CNT_W'(1);
        end else begin
          err_set_s[ERR_LINE] = beat_s;
          if (drain_r == DRN_W'(1)) begin
            done_nxt  = 1'b1;
            fcnt_nxt  = fcnt_r + FCNT_W'(1);
            state_nxt = IDLE;
            drain_nxt = '0;
          end else begin
            state_nxt = FLUSH;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        drain_nxt = '0;
      end
    endcase

    // Sticky errors: a new event beats a simultaneous clear.
    err_nxt    = ((err_r & ~{ERR_W{err_clr}}) | err_set_s) & ERR_MASK;
    active_nxt = (state_nxt != IDLE);
  end

  // FSM state register.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Counters, error register and registered outputs.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      gaus_en_r <= 1'b0;
      active_r  <= 1'b0;
      done_r    <= 1'b0;
      line_r    <= '0;
      col_r     <= '0;
      fcnt_r    <= '0;
      err_r     <= '0;
      drain_r   <= '0;
    end else begin
      gaus_en_r <= gaus_en_nxt;
      active_r  <= active_nxt;
      done_r    <= done_nxt;
      line_r    <= line_nxt;
      col_r     <= col_nxt;
      fcnt_r    <= fcnt_nxt;
      err_r     <= err_nxt;
      drain_r   <= drain_nxt;
    end
  end

  assign gaus_en      = gaus_en_r;
  assign frame_active = active_r;
  assign frame_done   = done_r;
  assign line_cnt     = line_r;
  assign col_cnt      = col_r;
  assign frame_cnt    = fcnt_r;
  assign err_status   = err_r;

endmodule

// File: tb/tb_gaus_frame_sched.sv
// Self-checking bench for gaus_frame_sched with an 8x4 image and 5-cycle
// drain. A frame-level reference model predicts every output after every
// clock; directed steps add explicit checks for the documented corner cases.
module tb_gaus_frame_sched;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int LAT = 5;
  localparam int CW = 12;
  localparam int WD = 16;

  logic          pixel_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          gaus_en_req = 1'b0;
  logic          err_clr = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          gaus_en;
  logic          frame_active;
  logic          frame_done;
  logic [CW-1:0] line_cnt;
  logic [CW-1:0] col_cnt;
  logic [15:0]   frame_cnt;
  logic [2:0]    err_status;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_fc   = 0;

  // Reference model: frame in progress, cycles left to drain, position.
  bit       m_in_frame;
  int       m_drain;
  int       m_line;
  int       m_col;
  int       m_idle;
  bit       m_gen;
  bit       m_done;
  int       m_fcnt;
  bit [2:0] m_err;

  gaus_frame_sched #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIPE_LAT   (LAT),
    .CNT_W      (CW),
    .WDOG_CYC   (WD)
  ) dut (
    .pixel_clk     (pixel_clk),
    .rst_n         (rst_n),
    .gaus_en_req   (gaus_en_req),
    .err_clr       (err_clr),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .gaus_en       (gaus_en),
    .frame_active  (frame_active),
    .frame_done    (frame_done),
    .line_cnt      (line_cnt),
    .col_cnt       (col_cnt),
    .frame_cnt     (frame_cnt),
    .err_status    (err_status)
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic void m_reset();
    m_in_frame = 1'b0; m_drain = 0; m_line = 0; m_col = 0; m_idle = 0;
    m_gen = 1'b0; m_done = 1'b0; m_fcnt = 0; m_err = 3'b000;
  endfunction

  function automatic void m_start(input bit req);
    m_in_frame = 1'b1; m_drain = 0; m_gen = req; m_line = 0; m_col = 1; m_idle = 0;
  endfunction

  // One clock of frame behaviour given the inputs seen at that edge.
  function automatic void m_step(input bit v, input bit u, input bit l, input bit req, input bit clr);
    bit [2:0] ev;
    ev = 3'b000;
    m_done = 1'b0;
    if (m_drain > 0) begin
      if (v && u) begin
        m_done = 1'b1;
        m_start(req);
      end else begin
        if (v) ev[0] = 1'b1;
        m_drain--;
        if (m_drain == 0) begin
          m_done = 1'b1;
          m_in_frame = 1'b0;
        end
      end
    end else if (m_in_frame) begin
      if (v && u) begin
        ev[1] = 1'b1;
        m_start(req);
      end else if (v) begin
        m_idle = 0;
        m_col++;
        if (l) begin
          if (m_col != W) ev[0] = 1'b1;
          m_col = 0;
          m_line++;
          if (m_line == H) m_drain = LAT;
        end
      end else begin
        m_idle++;
`ifdef GAUS_SCHED_WDOG_EN
        if (m_idle == WD) begin
          ev[2] = 1'b1;
          m_in_frame = 1'b0;
        end
`endif
      end
    end else if (v && u) begin
      m_start(req);
    end
    if (m_done) m_fcnt = (m_fcnt + 1) % 65536;
    m_err = (clr ? 3'b000 : m_err) | ev;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("gaus_en",      32'(gaus_en),      32'(m_gen));
    chk("frame_active", 32'(frame_active), 32'(m_in_frame));
    chk("frame_done",   32'(frame_done),   32'(m_done));
    chk("line_cnt",     32'(line_cnt),     32'(m_line));
    chk("col_cnt",      32'(col_cnt),      32'(m_col));
    chk("frame_cnt",    32'(frame_cnt),    32'(m_fcnt));
    chk("err_status",   32'(err_status),   32'(m_err));
  endtask

  task automatic cyc(input logic v, input logic u, input logic l, input logic clr);
    s_axis_tvalid = v; s_axis_tuser = u; s_axis_tlast = l; err_clr = clr;
    @(posedge pixel_clk);
    m_step(v, u, l, gaus_en_req, clr);
    #1;
    chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // A beat, optionally preceded by a random number of non-beat cycles whose
  // tuser/tlast are random (they must be ignored).
  task automatic beat(input logic u, input logic l, input logic clr, input int max_gap);
    int g;
    g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int i = 0; i < g; i++)
      cyc(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0);
    cyc(1'b1, u, l, clr);
  endtask

  // H lines; one line may be shortened, the request may flip at a line start,
  // and without SOF the first line resumes at beat 2.
  task automatic send_frame(input logic with_sof, input int short_ln, input int short_len,
                            input logic clr_short, input int flip_ln, input int max_gap);
    for (int ln = 0; ln < H; ln++) begin
      int len;
      int b0;
      len = (ln == short_ln) ? short_len : W;
      b0  = (ln == 0 && !with_sof) ? 2 : 1;
      if (ln == flip_ln) gaus_en_req = ~gaus_en_req;
      for (int b = b0; b <= len; b++)
        beat(with_sof && ln == 0 && b == 1, b == len,
             clr_short && ln == short_ln && b == len, max_gap);
    end
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge pixel_clk);
    #1;
    chk_all();
    chk("reset_gaus_en", 32'(gaus_en), 32'(0));
    chk("reset_err", 32'(err_status), 32'(0));
    #2 rst_n = 1'b1;

    // Nominal frame with enable requested; done exactly LAT cycles after last tlast.
    gaus_en_req = 1'b1;
    send_frame(1'b1, -1, 0, 1'b0, -1, 0);
    chk("nom_line_cnt", 32'(line_cnt), 32'(H));
    for (int k = 1; k <= LAT + 1; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("nom_done_lat", 32'(frame_done), 32'(k == LAT));
    end
    exp_fc++;
    chk("nom_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
    chk("nom_gaus_en", 32'(gaus_en), 32'(1));
    chk("nom_err", 32'(err_status), 32'(0));

    // Request drops mid-frame; enable only follows at the next SOF.
    send_frame(1'b1, -1, 0, 1'b0, 2, 1);
    chk("flip_hold", 32'(gaus_en), 32'(1));
    idle(LAT + 1);
    exp_fc++;
    send_frame(1'b1, -1, 0, 1'b0, -1, 0);
    chk("flip_new", 32'(gaus_en), 32'(0));
    idle(LAT + 1);
    exp_fc++;

    // Short line, clear, then clear colliding with a new short line.
    gaus_en_req = 1'b1;
    send_frame(1'b1, 1, 6, 1'b0, -1, 1);
    idle(LAT + 1);
    exp_fc++;
    chk("short_err", 32'(err_status), 32'(1));
    chk("short_line_cnt", 32'(line_cnt), 32'(H));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_err", 32'(err_status), 32'(0));
    send_frame(1'b1, 1, 6, 1'b1, -1, 0);
    chk("clr_vs_set", 32'(err_status), 32'(1));
    idle(LAT + 1);
    exp_fc++;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Premature SOF (with coincident tlast) on beat 3 of the first line.
    beat(1'b1, 1'b0, 1'b0, 0);
    beat(1'b0, 1'b0, 1'b0, 0);
    beat(1'b1, 1'b1, 1'b0, 0);
    chk("psof_err", 32'(err_status), 32'(2));
    chk("psof_line", 32'(line_cnt), 32'(0));
    chk("psof_col", 32'(col_cnt), 32'(1));
    chk("psof_done", 32'(frame_done), 32'(0));
    chk("psof_fcnt", 32'(frame_cnt), 32'(exp_fc));
    send_frame(1'b0, -1, 0, 1'b0, -1, 0);
    idle(LAT + 1);
    exp_fc++;
    chk("psof_fcnt_end", 32'(frame_cnt), 32'(exp_fc));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: SOF two cycles after the final tlast.
    send_frame(1'b1, -1, 0, 1'b0, -1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 0);
    exp_fc++;
    chk("b2b_done", 32'(frame_done), 32'(1));
    chk("b2b_fcnt", 32'(frame_cnt), 32'(exp_fc));
    chk("b2b_active", 32'(frame_active), 32'(1));
    chk("b2b_err", 32'(err_status), 32'(0));
    send_frame(1'b0, -1, 0, 1'b0, -1, 0);
    idle(LAT + 1);
    exp_fc++;
    chk("b2b_fcnt_end", 32'(frame_cnt), 32'(exp_fc));

    // Input stall of WD cycles right after SOF.
    beat(1'b1, 1'b0, 1'b0, 0);
    idle(WD);
`ifdef GAUS_SCHED_WDOG_EN
    chk("wdog_err", 32'(err_status), 32'(4));
    chk("wdog_active", 32'(frame_active), 32'(0));
    chk("wdog_done", 32'(frame_done), 32'(0));
    send_frame(1'b0, -1, 0, 1'b0, -1, 0);
    idle(LAT + 1);
    chk("wdog_fcnt", 32'(frame_cnt), 32'(exp_fc));
    chk("wdog_stay_idle", 32'(frame_active), 32'(0));
`else
    chk("stall_active", 32'(frame_active), 32'(1));
    chk("stall_err", 32'(err_status), 32'(0));
    send_frame(1'b0, -1, 0, 1'b0, -1, 0);
    idle(LAT + 1);
    exp_fc++;
    chk("stall_fcnt", 32'(frame_cnt), 32'(exp_fc));
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Well-formed frames with random gaps and random request.
    for (int f = 0; f < 3; f++) begin
      gaus_en_req = 1'($urandom_range(1, 0));
      send_frame(1'b1, -1, 0, 1'b0, -1, 3);
      idle(int'($urandom_range(LAT + 2, 1)));
    end

    // Fully random sideband traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15, 0) == 0) gaus_en_req = ~gaus_en_req;
      cyc($urandom_range(9, 0) < 7, $urandom_range(29, 0) == 0,
          $urandom_range(6, 0) == 0, $urandom_range(19, 0) == 0);
    end

    // Asynchronous reset in the middle of a frame.
    gaus_en_req = 1'b1;
    beat(1'b1, 1'b0, 1'b0, 0);
    beat(1'b0, 1'b0, 1'b0, 0);
    beat(1'b0, 1'b0, 1'b0, 0);
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0; err_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gaus_en", 32'(gaus_en), 32'(0));
    chk("arst_active", 32'(frame_active), 32'(0));
    chk("arst_line", 32'(line_cnt), 32'(0));
    chk("arst_col", 32'(col_cnt), 32'(0));
    chk("arst_fcnt", 32'(frame_cnt), 32'(0));
    chk("arst_err", 32'(err_status), 32'(0));
    chk("arst_done", 32'(frame_done), 32'(0));
    m_reset();
    @(posedge pixel_clk);
    #1;
    chk_all();
    #2 rst_n = 1'b1;
    exp_fc = 0;
    beat(1'b0, 1'b0, 1'b0, 0);
    beat(1'b0, 1'b1, 1'b0, 0);
    chk("arst_need_sof", 32'(frame_active), 32'(0));
    send_frame(1'b1, -1, 0, 1'b0, -1, 0);
    idle(LAT + 1);
    exp_fc++;
    chk("arst_fcnt_end", 32'(frame_cnt), 32'(exp_fc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gaus_frame_sched.md
Name: gaus_frame_sched

Overview:
Frame-level controller for the 3x3 Gaussian filter stage in the gray ISP path. It monitors the AXI-Stream sideband entering the filter and applies the software filter-enable request only at frame boundaries. It tracks line/column position, checks frame geometry, and issues a frame-done pulse once the filter pipeline has drained. Filter enable, status and counters feed the ISP register block.

Parameters:
IMG_WIDTH, 640, active pixels per line
IMG_HEIGHT, 480, lines per frame
PIPE_LAT, 5, filter input-to-output latency in pixel_clk cycles; drain length
CNT_W, 12, width of line/column counters
WDOG_CYC, 4096, idle-cycle limit for the watchdog (used only with the optional feature)

Ports:
pixel_clk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
gaus_en_req  in  1  software filter-enable request, may change any time
err_clr  in  1  one-cycle pulse; clears err_status
s_axis_tvalid  in  1  stream valid at filter input (no backpressure)
s_axis_tuser  in  1  start of frame, qualified by tvalid
s_axis_tlast  in  1  end of line, qualified by tvalid
gaus_en  out  1  filter enable to the filter; changes only at accepted SOF
frame_active  out  1  high in ACTIVE and FLUSH
frame_done  out  1  one-cycle pulse when frame output is complete
line_cnt  out  CNT_W  completed lines in current frame
col_cnt  out  CNT_W  beats received in current line
frame_cnt  out  16  completed frames, wraps at 0xFFFF->0
err_status  out  3  sticky: [0] bad line length, [1] premature SOF, [2] watchdog

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, including gaus_en.
- Beat = cycle with s_axis_tvalid=1. tuser/tlast are ignored without tvalid.
- IDLE: beat with tuser -> ACTIVE. On that edge: gaus_en <= gaus_en_req; line_cnt <= 0; col_cnt <= 1. Beats without tuser are ignored.
- ACTIVE, every beat: col_cnt += 1.
- ACTIVE, beat with tlast:
  - If col_cnt+1 != IMG_WIDTH, set err_status[0].
  - col_cnt <= 0; line_cnt += 1.
  - If line_cnt+1 == IMG_HEIGHT: go to FLUSH and load the drain counter with PIPE_LAT.
- ACTIVE, beat with tuser (premature SOF):
  - Set err_status[1].
  - Restart the frame with the IDLE->ACTIVE actions (relatch gaus_en, line_cnt=0, col_cnt=1).
  - No frame_done pulse; frame_cnt is unchanged.
  - tuser takes priority over a simultaneous tlast.
- FLUSH: the drain counter decrements every cycle, independent of input.
  - Non-tuser beats set err_status[0].
  - When the counter reaches 1: frame_done=1 for one cycle, frame_cnt += 1, go to IDLE. frame_done therefore rises PIPE_LAT cycles after the last tlast beat.
  - Beat with tuser during FLUSH: frame_done and frame_cnt++ happen on that cycle, and the new frame starts ACTIVE with the SOF actions (back-to-back frames).
- gaus_en never changes mid-frame. A gaus_en_req toggle mid-frame takes effect at the next accepted SOF.
- err_status bits are sticky. If err_clr and a new error event occur in the same cycle, set wins.
- Counters saturate nowhere except frame_cnt, which wraps. col_cnt is CNT_W wide; IMG_WIDTH must be < 2^CNT_W (elaboration check).
- Reset mid-frame: immediate return to IDLE with all outputs cleared. The next frame requires a fresh tuser.

Optional Feature:
GAUS_SCHED_WDOG_EN
- Defined: in ACTIVE, an idle counter counts consecutive non-beat cycles and clears on any beat. Reaching WDOG_CYC sets err_status[2] and returns to IDLE without frame_done. frame_active drops on the next cycle.
- Undefined: no watchdog logic; err_status[2] is tied to 0; ACTIVE waits indefinitely.

Decomposition:
- Package gaus_sched_pkg holds:
  - state encoding constants IDLE=2'd0, ACTIVE=2'd1, FLUSH=2'd2
  - error bit indices ERR_LINE=0, ERR_SOF=1, ERR_WDOG=2
  - frame_cnt width constant FCNT_W=16
- One sub-module, gaus_sched_wdog (idle counter with clear/expire), is instantiated only under GAUS_SCHED_WDOG_EN.
- The FSM, counters and error register stay in the top module.

Test Plan:
(All with IMG_WIDTH=8, IMG_HEIGHT=4, PIPE_LAT=5 unless noted.)
- Nominal frame, gaus_en_req=1: SOF, then 4 lines of 8 beats each, tlast on beat 8 -> gaus_en=1 from the cycle after SOF; line_cnt reaches 4; frame_done pulses exactly 5 cycles after the final tlast; frame_cnt=1; err_status=0.
- gaus_en_req toggled 1->0 mid-frame -> gaus_en stays 1 until the next SOF, then reads 0.
- Short line (tlast on beat 6 of line 2) -> err_status[0]=1, line_cnt still advances; err_clr pulse -> err_status=0. err_clr coinciding with a new error -> bit remains 1.
- tuser on beat 3 of line 1 -> err_status[1]=1; line_cnt=0 and col_cnt=1 after that beat; no frame_done; frame_cnt unchanged.
- Back-to-back frames, SOF 2 cycles after the final tlast -> frame_done on the SOF cycle, frame_cnt+1, new frame ACTIVE, no errors.
- With GAUS_SCHED_WDOG_EN and WDOG_CYC=16: stall tvalid for 16 cycles mid-frame -> err_status[2]=1, state IDLE, frame_active=0, no frame_done. rst_n asserted mid-frame -> all outputs 0 asynchronously.
